// File: rtl/timer_device_pkg.sv
// Shared constants for the countdown timer: register offsets, CTRL bit fields,
// FSM encoding and the base address the bridge decodes for this device.
package timer_device_pkg;

   localparam logic [31:0] TIMER_BASE = 32'h1000_0000;

   // Word offsets as seen on addr[3:2]
   localparam logic [1:0] TIMER_CTRL   = 2'd0;
   localparam logic [1:0] TIMER_PRESET = 2'd1;
   localparam logic [1:0] TIMER_COUNT  = 2'd2;
   localparam logic [1:0] TIMER_RSVD   = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } timerState_t;

   // Field order matches the CTRL bit positions above, MSB first
   typedef struct packed {
      logic       im;
      logic [1:0] mode;
      logic       en;
   } ctrlReg_t;

endpackage

// File: rtl/timer_device.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot and periodic
// modes and a level interrupt request gated by CTRL.IM.
module timer_device
   import timer_device_pkg::*;
#(
   parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        irq
);

   timerState_t state, stateNext;
   ctrlReg_t    ctrl, ctrlNext;
   logic [31:0] preset, presetNext;
   logic [31:0] count, countNext;
   logic        irqFlag, irqFlagNext;
   logic        setFlag;
   logic        wrCtrl, wrPreset;
   logic [1:0]  regSel;
   logic        unusedAddrBits;

   assign regSel         = addr[3:2];
   assign unusedAddrBits = ^{addr[31:4], addr[1:0]};
   assign wrCtrl         = we && (regSel == TIMER_CTRL);
   assign wrPreset       = we && (regSel == TIMER_PRESET);

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  laneEn);
      logic [31:0] merged;
      merged = oldVal;
      for (int i = 0; i < 4; i++) begin
         if (laneEn[i]) merged[8*i +: 8] = newVal[8*i +: 8];
      end
      return merged;
   endfunction

   always_comb begin
      // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
      stateNext   = state;
      ctrlNext    = ctrl;
      presetNext  = preset;
      countNext   = count;
      irqFlagNext = irqFlag;
      setFlag     = 1'b0;

      case (state)
         IDLE: begin
            if (ctrl.en) stateNext = LOAD;
         end
         LOAD: begin
            countNext = preset;
            stateNext = CNT;
         end
         CNT: begin
            if (!ctrl.en) begin
               stateNext = IDLE;
            end else if (count == 32'd0) begin
               stateNext = INT;
               setFlag   = 1'b1;
            end else begin
               countNext = count - 32'd1;
            end
         end
         INT: begin
            if (ctrl.mode == MODE_PERIODIC) begin
               irqFlagNext = 1'b0;
               stateNext   = LOAD;
            end else begin
               // Reserved modes (1x) behave as one-shot
               ctrlNext.en = 1'b0;
               stateNext   = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase

      // Bus writes are applied after the FSM so a CTRL write overrides the EN clear
      if (wrCtrl && be[0]) ctrlNext = ctrlReg_t'(wd[3:0]);
      if (wrPreset) presetNext = mergeBytes(preset, wd, be);
      if (wrCtrl || wrPreset) irqFlagNext = 1'b0;
      if (setFlag) irqFlagNext = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ctrl    <= '0;
         preset  <= RESET_PRESET;
         count   <= '0;
         irqFlag <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state   <= stateNext;
         ctrl    <= ctrlNext;
         preset  <= presetNext;
         count   <= countNext;
         irqFlag <= irqFlagNext;
      end
   end

   always_comb begin
      rd = 32'd0;
      case (regSel)
         TIMER_CTRL:   rd = {28'd0, ctrl};
         TIMER_PRESET: rd = preset;
         TIMER_COUNT:  rd = count;
         TIMER_RSVD:   rd = 32'd0;
         default:      rd = 32'd0;
      endcase
   end

   assign irq = ctrl.im & irqFlag;

endmodule
